// File: rtl/eth_activity_monitor.sv
// Ethernet activity LED driver and saturating RX/TX packet counters.
// The block only watches the AXI-Stream handshakes; it never drives them.
module eth_activity_monitor #(
  parameter int unsigned FREQ_HZ = 250000000,
  parameter int unsigned ON_MS   = 50,
  parameter int unsigned OFF_MS  = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        link_status,
  input  logic        rx_tvalid,
  input  logic        rx_tready,
  input  logic        rx_tlast,
  input  logic        tx_tvalid,
  input  logic        tx_tready,
  input  logic        tx_tlast,
  input  logic        clear_counters,
  output logic        activity,
  output logic [31:0] rx_packets,
  output logic [31:0] tx_packets
);

  localparam int unsigned CYC_MS = FREQ_HZ / 1000;
  localparam int unsigned PRE_W  = (CYC_MS > 1) ? $clog2(CYC_MS) : 1;
  localparam int unsigned MAX_MS = (ON_MS > OFF_MS) ? ON_MS : OFF_MS;
  localparam int unsigned MS_W   = $clog2(MAX_MS + 1);

  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

  state_t            state, state_d;
  logic              pending;
  logic [PRE_W-1:0]  pre;
  logic [MS_W-1:0]   ms_cnt;
  logic [31:0]       rx_cnt, tx_cnt;

  logic beat, ms_tick, on_done, off_done, entering;

  // One activity event per cycle, regardless of which stream(s) moved data.
  assign beat     = (rx_tvalid & rx_tready) | (tx_tvalid & tx_tready);
  assign ms_tick  = (pre == PRE_W'(CYC_MS - 1));
  assign on_done  = ms_tick && (ms_cnt == MS_W'(ON_MS - 1));
  assign off_done = ms_tick && (ms_cnt == MS_W'(OFF_MS - 1));
  assign entering = (state_d != state);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next-state logic; a dropped link overrides every other transition.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (beat)     state_d = ON;
      ON:      if (on_done)  state_d = OFF;
      OFF:     if (off_done) state_d = pending ? ON : IDLE;
      default:               state_d = IDLE;
    endcase
    if (!link_status) state_d = IDLE;
  end

  // LED follows the next state so it is a clean flop output equal to (state == ON).
  always_ff @(posedge clk) begin
    if (reset) activity <= 1'b0;
    else       activity <= (state_d == ON);
  end

  // Remember traffic seen during a blink so one more blink follows the dark time.
  // Clearing on entry wins over a beat in the same cycle.
  always_ff @(posedge clk) begin
    if (reset)                                             pending <= 1'b0;
    else if (entering && (state_d == ON || state_d == IDLE)) pending <= 1'b0;
    else if (!link_status)                                 pending <= 1'b0;
    else if (beat && state != IDLE)                        pending <= 1'b1;
  end

  // ms prescaler and ms counter; both restart on every state change and idle at 0.
  always_ff @(posedge clk) begin
    if (reset || entering || state == IDLE) begin
      pre    <= '0;
      ms_cnt <= '0;
    end else if (ms_tick) begin
      pre    <= '0;
      ms_cnt <= ms_cnt + MS_W'(1);
    end else begin
      pre    <= pre + PRE_W'(1);
    end
  end

  // RX packet counter: clear beats increment, saturates at all ones.
  always_ff @(posedge clk) begin
    if (reset || clear_counters)                              rx_cnt <= '0;
    else if (rx_tvalid && rx_tready && rx_tlast && rx_cnt != '1) rx_cnt <= rx_cnt + 32'd1;
  end

  // TX packet counter, same rules as RX.
  always_ff @(posedge clk) begin
    if (reset || clear_counters)                              tx_cnt <= '0;
    else if (tx_tvalid && tx_tready && tx_tlast && tx_cnt != '1) tx_cnt <= tx_cnt + 32'd1;
  end

  assign rx_packets = rx_cnt;
  assign tx_packets = tx_cnt;

endmodule
